// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM states, slice width,
// and the two's-complement overflow rule.
package nibble_serial_subtractor_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // a - b overflows only when the operand signs differ and the result sign
  // disagrees with the minuend.
  function automatic logic sub_overflow(input logic sign_a,
                                        input logic sign_b,
                                        input logic sign_d);
    return (sign_a != sign_b) && (sign_d != sign_a);
  endfunction

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational 4-bit slice computing a + ~b + cin as a ripple chain of full
// adders; one slice is reused for every nibble of the operation.
module nibble_sub_slice
  import nibble_serial_subtractor_pkg::*;
(
  input  logic [NIBBLE_W-1:0] i_a,
  input  logic [NIBBLE_W-1:0] i_b,
  input  logic                i_cin,
  output logic [NIBBLE_W-1:0] o_sum,
  output logic                o_cout
);

  logic [NIBBLE_W:0]   w_c;
  logic [NIBBLE_W-1:0] w_nb;

  assign w_nb   = ~i_b;
  assign w_c[0] = i_cin;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign o_sum[i]  = i_a[i] ^ w_nb[i] ^ w_c[i];
    assign w_c[i+1]  = (i_a[i] & w_nb[i]) | (w_c[i] & (i_a[i] ^ w_nb[i]));
  end

  assign o_cout = w_c[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle subtractor: diff = a - b, one nibble per clock (LSB first)
// through a single 4-bit slice, with a start/busy/done handshake.
module nibble_serial_subtractor
  import nibble_serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             r_state;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_diff;
  logic               r_carry;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_sign_a;
  logic               r_sign_b;
  logic               r_busy;
  logic               r_done;
  logic               r_borrow;
  logic               r_ovf;
  logic               r_zero;

  logic [NIBBLE_W:0]  w_s;
  logic [WIDTH-1:0]   w_diff_next;
  logic               w_last;

  nibble_sub_slice u_slice (
    .i_a    (r_a[NIBBLE_W-1:0]),
    .i_b    (r_b[NIBBLE_W-1:0]),
    .i_cin  (r_carry),
    .o_sum  (w_s[NIBBLE_W-1:0]),
    .o_cout (w_s[NIBBLE_W])
  );

  // New nibble enters at the MSB end; after NIB shifts it sits in place.
  assign w_diff_next = (r_diff >> NIBBLE_W)
                     | (WIDTH'(w_s[NIBBLE_W-1:0]) << (WIDTH - NIBBLE_W));
  assign w_last      = (r_cnt == CNT_W'(NIB - 1));

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values, matching the hardware regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_diff   <= '0;
      r_carry  <= 1'b0;
      r_cnt    <= '0;
      r_sign_a <= 1'b0;
      r_sign_b <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_carry  <= 1'b1;
            r_cnt    <= '0;
            r_sign_a <= a[WIDTH-1];
            r_sign_b <= b[WIDTH-1];
            r_busy   <= 1'b1;
            r_state  <= RUN;
          end
        end
        RUN: begin
          r_diff  <= w_diff_next;
          r_carry <= w_s[NIBBLE_W];
          r_a     <= r_a >> NIBBLE_W;
          r_b     <= r_b >> NIBBLE_W;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_borrow <= ~w_s[NIBBLE_W];
            r_ovf    <= sub_overflow(r_sign_a, r_sign_b, w_s[NIBBLE_W-1]);
            r_zero   <= (w_diff_next == '0);
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= DONE;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;
  assign zero   = r_zero;

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Self-checking bench for nibble_serial_subtractor (WIDTH=16): directed and
// randomized operations compared against an integer-arithmetic reference.
module tb_nibble_serial_subtractor;

  localparam int W   = 16;
  localparam int NIB = W / 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         borrow;
  logic         ovf;
  logic         zero;

  int n_pass  = 0;
  int n_total = 0;

  nibble_serial_subtractor #(.WIDTH(W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .a      (a),
    .b      (b),
    .busy   (busy),
    .done   (done),
    .diff   (diff),
    .borrow (borrow),
    .ovf    (ovf),
    .zero   (zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: {diff, borrow, ovf, zero} from plain integer arithmetic.
  function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb);
    longint ua, ub, sa, sb, sd;
    logic [W-1:0] d;
    logic br, ov, z;
    ua = longint'(ma);
    ub = longint'(mb);
    sa = (ua >= (64'sd1 << (W - 1))) ? ua - (64'sd1 << W) : ua;
    sb = (ub >= (64'sd1 << (W - 1))) ? ub - (64'sd1 << W) : ub;
    sd = sa - sb;
    d  = W'((ua - ub + (64'sd1 << W)) % (64'sd1 << W));
    br = (ua < ub);
    ov = (sd > (64'sd1 << (W - 1)) - 1) || (sd < -(64'sd1 << (W - 1)));
    z  = (d == '0);
    return {d, br, ov, z};
  endfunction

  function automatic logic [W+2:0] observed();
    return {diff, borrow, ovf, zero};
  endfunction

  // Issue one operation from IDLE and check busy, latency, result and hold.
  task automatic run_op(input logic [W-1:0] ia, input logic [W-1:0] ib, input string name);
    logic [W+2:0] exp_r;
    logic [W+2:0] got_r;
    int lat;
    exp_r = model(ia, ib);
    @(negedge clk);
    a = ia; b = ib; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = $urandom(); b = $urandom();
    n_total++;
    if (busy !== 1'b1 || done !== 1'b0)
      $display("FAIL %s busy_after_start: busy=%b done=%b expected busy=1 done=0", name, busy, done);
    else n_pass++;
    lat = 0;
    for (int k = 1; k <= 3 * NIB; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = k; break; end
    end
    n_total++;
    if (lat != NIB)
      $display("FAIL %s latency: done after %0d edges, expected %0d", name, lat, NIB);
    else n_pass++;
    n_total++;
    if (busy !== 1'b0)
      $display("FAIL %s busy_at_done: busy=%b expected 0", name, busy);
    else n_pass++;
    got_r = observed();
    n_total++;
    if (got_r !== exp_r)
      $display("FAIL %s result: a=%h b=%h got diff=%h br=%b ovf=%b z=%b expected diff=%h br=%b ovf=%b z=%b",
               name, ia, ib, got_r[W+2:3], got_r[2], got_r[1], got_r[0],
               exp_r[W+2:3], exp_r[2], exp_r[1], exp_r[0]);
    else n_pass++;
    @(posedge clk); #1;
    n_total++;
    if (done !== 1'b0 || busy !== 1'b0 || observed() !== exp_r)
      $display("FAIL %s hold: done=%b busy=%b diff=%h expected done=0 busy=0 diff=%h",
               name, done, busy, diff, exp_r[W+2:3]);
    else n_pass++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({busy, done, diff, borrow, ovf, zero} !== '0)
      $display("FAIL reset_state: busy=%b done=%b diff=%h br=%b ovf=%b z=%b expected all 0",
               busy, done, diff, borrow, ovf, zero);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
  endtask

  task automatic test_directed();
    run_op(16'h1234, 16'h0234, "nominal");
    run_op(16'h0000, 16'h0001, "wrap");
    run_op(16'h0003, 16'hFFFF, "borrow_small");
    run_op(16'h8000, 16'h0001, "ovf_neg");
    run_op(16'h7FFF, 16'hFFFF, "ovf_pos");
    run_op(16'h5A5A, 16'h5A5A, "zero");
    run_op(16'h0001, 16'h0000, "zero_clear");
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom());
      rb = W'($urandom());
      case (i % 5)
        0: rb = ra;
        1: ra = {1'b1, ra[W-2:0]};
        2: rb = ra + W'(1);
        default: ;
      endcase
      run_op(ra, rb, "random");
    end
  endtask

  task automatic test_handshake();
    logic [W+2:0] exp_r;
    int lat, extra;
    exp_r = model(16'h0010, 16'h0001);
    @(negedge clk);
    a = 16'h0010; b = 16'h0001; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    lat = 0;
    for (int k = 2; k <= 3 * NIB; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin lat = k; break; end
    end
    n_total++;
    if (lat != NIB)
      $display("FAIL handshake_latency: done after %0d edges, expected %0d", lat, NIB);
    else n_pass++;
    n_total++;
    if (observed() !== exp_r)
      $display("FAIL handshake_result: diff=%h expected %h", diff, exp_r[W+2:3]);
    else n_pass++;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b0 || done !== 1'b0)
      $display("FAIL handshake_done_start: busy=%b done=%b expected 0 0", busy, done);
    else n_pass++;
    @(negedge clk);
    start = 1'b0;
    extra = 0;
    for (int k = 0; k < 2 * NIB; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) extra++;
    end
    n_total++;
    if (extra != 0 || observed() !== exp_r)
      $display("FAIL handshake_ignored: activity=%0d diff=%h expected activity=0 diff=%h",
               extra, diff, exp_r[W+2:3]);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] ra, rb;
    logic [W+2:0] exp_r;
    int t0, t1, n_done;
    ra = W'($urandom()); rb = W'($urandom());
    exp_r = model(ra, rb);
    @(negedge clk);
    a = ra; b = rb; start = 1'b1;
    @(posedge clk);
    t0 = -1; t1 = -1; n_done = 0;
    for (int k = 1; k <= 4 * NIB && n_done < 2; k++) begin
      @(posedge clk); #1;
      if (done === 1'b1) begin
        n_total++;
        if (observed() !== exp_r)
          $display("FAIL b2b_result: diff=%h expected %h", diff, exp_r[W+2:3]);
        else n_pass++;
        if (n_done == 0) t0 = k; else t1 = k;
        n_done++;
      end
    end
    @(negedge clk);
    start = 1'b0;
    n_total++;
    if (n_done != 2 || (t1 - t0) != NIB + 2)
      $display("FAIL b2b_throughput: dones=%0d gap=%0d expected dones=2 gap=%0d",
               n_done, t1 - t0, NIB + 2);
    else n_pass++;
    repeat (NIB + 2) @(posedge clk);
  endtask

  task automatic test_reset_midop();
    int seen;
    @(negedge clk);
    a = 16'h9999; b = 16'h1111; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_total++;
    if ({busy, done, diff, borrow, ovf, zero} !== '0)
      $display("FAIL reset_midop_clear: busy=%b done=%b diff=%h br=%b ovf=%b z=%b expected all 0",
               busy, done, diff, borrow, ovf, zero);
    else n_pass++;
    seen = 0;
    repeat (2) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (NIB + 2) begin
      @(posedge clk); #1;
      if (done === 1'b1 || busy === 1'b1) seen++;
    end
    n_total++;
    if (seen != 0)
      $display("FAIL reset_midop_no_done: activity=%0d expected 0", seen);
    else n_pass++;
    run_op(16'h0005, 16'h0003, "after_reset");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_handshake();
    test_back_to_back();
    test_random();
    test_reset_midop();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
